// File: rtl/irq_pkg.sv
// Shared types, register indices and vector arithmetic for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

  // Controller handshake state: IDLE searches for a candidate, REQ presents it to the CPU.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_e;

  // Byte-wide register port indices.
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_MODE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_INSV = 2'd3;

  // Channel index width; the controller supports at most 8 channels.
  localparam int IDX_W = 3;

  // Handler address of channel idx.
  function automatic logic [15:0] vec_addr(
    input logic [15:0]      base,
    input logic [15:0]      stride,
    input logic [IDX_W-1:0] idx
  );
    return base + (stride * {{(16-IDX_W){1'b0}}, idx});
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder with valid flag and one-hot grant.
// Latency: purely combinational.
// Backpressure: none; outputs follow i_req directly.
//
// Ports:
//   i_req    - request vector, bit 0 is highest priority
//   o_vld    - at least one request bit is set
//   o_idx    - index of the winning bit (0 when o_vld=0)
//   o_onehot - winning bit as a one-hot vector (all zero when o_vld=0)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx,
  output logic [WIDTH-1:0] o_onehot
);

  // Scan from the top so the lowest set bit is the last assignment to stick.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = i[IDX_W-1:0];
      end
    end
  end

  assign o_vld    = |i_req;
  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_req & (~i_req + WIDTH'(1));

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel sync, toggle/level detect, mask, pending, nested in-service, vector/ack handshake.
// Latency: input change -> PENDING after SYNC_STAGES+1 edges -> O_IRQ one edge later; register reads one edge.
// Backpressure: a request is held in REQ until I_ACK or until its pending/mask bit drops; one idle cycle follows.
//
// Ports:
//   CLOCK, RESET_N             - clock, asynchronous active-low reset
//   I_IRQ                      - raw peripheral event lines
//   I_CS/I_WREN/I_REG/I_DATA   - register port (MASK, MODE, PENDING W1C, INSERVICE RO)
//   O_DATA                     - registered read data
//   O_IRQ/O_VECTOR             - registered request and handler address to the CPU
//   I_ACK/I_EOI                - vector taken / handler finished pulses
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'h0002,
  parameter int          VEC_STRIDE  = 2
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic [NUM_IRQ-1:0] I_IRQ,
  input  logic               I_CS,
  input  logic               I_WREN,
  input  logic [1:0]         I_REG,
  input  logic [7:0]         I_DATA,
  output logic [7:0]         O_DATA,
  output logic               O_IRQ,
  output logic [15:0]        O_VECTOR,
  input  logic               I_ACK,
  input  logic               I_EOI
);

  // Synchroniser and edge detection state.
  logic [NUM_IRQ-1:0]     r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic [NUM_IRQ-1:0]     r_hist;
  logic                   r_hist_vld;
  logic [NUM_IRQ-1:0]     r_evt;

  // Software-visible registers.
  logic [NUM_IRQ-1:0]     r_mask;
  logic [NUM_IRQ-1:0]     r_mode;
  logic [NUM_IRQ-1:0]     r_pend;
  logic [NUM_IRQ-1:0]     r_insv;
  logic [7:0]             r_rdata;

  // Handshake state.
  irq_state_e             r_state;
  logic                   r_irq;
  logic [15:0]            r_vec;
  logic [NUM_IRQ-1:0]     r_req_oh;
  logic                   r_cool;

  logic [NUM_IRQ-1:0]     w_sync;
  logic                   w_sync_vld;
  logic                   w_wr_mask;
  logic                   w_wr_mode;
  logic                   w_wr_pend;
  logic [NUM_IRQ-1:0]     w_wdat;
  logic [NUM_IRQ-1:0]     w_rsel;
  logic [NUM_IRQ-1:0]     w_pend_nxt;
  logic [NUM_IRQ-1:0]     w_insv_nxt;
  logic [NUM_IRQ-1:0]     w_allowed;
  logic [NUM_IRQ-1:0]     w_cand;
  logic                   w_cand_vld;
  logic [IDX_W-1:0]       w_cand_idx;
  logic [NUM_IRQ-1:0]     w_cand_oh;
  logic                   w_insv_vld;
  logic [IDX_W-1:0]       w_insv_idx;
  logic [NUM_IRQ-1:0]     w_insv_oh;
  irq_state_e             w_state_nxt;
  logic                   w_irq_nxt;
  logic [15:0]            w_vec_nxt;
  logic [NUM_IRQ-1:0]     w_req_oh_nxt;
  logic                   w_cool_nxt;
  logic                   w_ack_take;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_sync_vld = r_sync_vld[SYNC_STAGES-1];

  // A valid bit travels beside the synchroniser so the history flop is primed
  // from the first real sample; lines already high at reset release never look
  // like a toggle. The event is registered once more before it reaches PENDING.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_sync_vld <= '0;
      r_hist     <= '0;
      r_hist_vld <= 1'b0;
      r_evt      <= '0;
    end else begin
      r_sync[0]     <= I_IRQ;
      r_sync_vld[0] <= 1'b1;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s]     <= r_sync[s-1];
        r_sync_vld[s] <= r_sync_vld[s-1];
      end
      r_hist     <= w_sync;
      r_hist_vld <= w_sync_vld;
      r_evt      <= (r_hist_vld && w_sync_vld) ? (w_sync ^ r_hist) : '0;
    end
  end

  assign w_wdat    = I_DATA[NUM_IRQ-1:0];
  assign w_wr_mask = I_CS && I_WREN && (I_REG == REG_MASK);
  assign w_wr_mode = I_CS && I_WREN && (I_REG == REG_MODE);
  assign w_wr_pend = I_CS && I_WREN && (I_REG == REG_PEND);

  // Toggle channels: W1C and ACK clear, a fresh event sets last so it wins.
  // Level channels ignore all of that and mirror the synchronised line.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_pend) begin
      w_pend_nxt = w_pend_nxt & ~w_wdat;
    end
    if (w_ack_take) begin
      w_pend_nxt = w_pend_nxt & ~r_req_oh;
    end
    w_pend_nxt = w_pend_nxt | r_evt;
    w_pend_nxt = (w_pend_nxt & ~r_mode) | (w_sync & r_mode);
  end

  // EOI retires the highest-priority in-service bit before ACK adds the new one.
  assign w_insv_nxt = (r_insv & ~(I_EOI ? w_insv_oh : '0)) | (w_ack_take ? r_req_oh : '0);

  irq_prio_enc #(.WIDTH(NUM_IRQ)) u_insv_enc (
    .i_req    (r_insv),
    .o_vld    (w_insv_vld),
    .o_idx    (w_insv_idx),
    .o_onehot (w_insv_oh)
  );

  // Only channels strictly above the highest-priority in-service one may nest.
  always_comb begin
    w_allowed = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_allowed[i] = !w_insv_vld || (i < int'(w_insv_idx));
    end
  end

  assign w_cand = r_pend & r_mask & ~r_insv & w_allowed;

  irq_prio_enc #(.WIDTH(NUM_IRQ)) u_cand_enc (
    .i_req    (w_cand),
    .o_vld    (w_cand_vld),
    .o_idx    (w_cand_idx),
    .o_onehot (w_cand_oh)
  );

  always_comb begin
    case (I_REG)
      REG_MASK: w_rsel = r_mask;
      REG_MODE: w_rsel = r_mode;
      REG_PEND: w_rsel = r_pend;
      default:  w_rsel = r_insv;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_insv  <= '0;
      r_rdata <= 8'h00;
    end else begin
      if (w_wr_mask) begin
        r_mask <= w_wdat;
      end
      if (w_wr_mode) begin
        r_mode <= w_wdat;
      end
      r_pend <= w_pend_nxt;
      r_insv <= w_insv_nxt;
      if (I_CS && !I_WREN) begin
        r_rdata <= 8'(w_rsel);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_irq    <= 1'b0;
      r_vec    <= 16'h0000;
      r_req_oh <= '0;
      r_cool   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq    <= w_irq_nxt;
      r_vec    <= w_vec_nxt;
      r_req_oh <= w_req_oh_nxt;
      r_cool   <= w_cool_nxt;
    end
  end

  // r_cool forces one idle cycle after leaving REQ, so O_IRQ is seen low by
  // the CPU and the updated INSERVICE settles before the next selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_irq_nxt    = 1'b0;
    w_vec_nxt    = r_vec;
    w_req_oh_nxt = r_req_oh;
    w_cool_nxt   = 1'b0;
    w_ack_take   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_cool && w_cand_vld) begin
          w_state_nxt  = REQ;
          w_irq_nxt    = 1'b1;
          w_vec_nxt    = vec_addr(VEC_BASE, 16'(VEC_STRIDE), w_cand_idx);
          w_req_oh_nxt = w_cand_oh;
        end
      end
      REQ: begin
        w_irq_nxt = 1'b1;
        if (I_ACK) begin
          w_ack_take  = 1'b1;
          w_state_nxt = IDLE;
          w_irq_nxt   = 1'b0;
          w_cool_nxt  = 1'b1;
        end else if ((r_pend & r_mask & r_req_oh) == '0) begin
          // Source went away or was masked: withdraw without servicing.
          w_state_nxt = IDLE;
          w_irq_nxt   = 1'b0;
          w_cool_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign O_IRQ    = r_irq;
  assign O_VECTOR = r_vec;
  assign O_DATA   = r_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with 8 channels, 2 sync stages, base 0x0002, stride 2.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        CLOCK   = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  I_IRQ;
  logic        I_CS    = 1'b0;
  logic        I_WREN  = 1'b0;
  logic [1:0]  I_REG   = 2'd0;
  logic [7:0]  I_DATA  = 8'h00;
  logic [7:0]  O_DATA;
  logic        O_IRQ;
  logic [15:0] O_VECTOR;
  logic        I_ACK   = 1'b0;
  logic        I_EOI   = 1'b0;

  logic [7:0]  irq_lines = 8'h00;
  int          total = 0;
  int          bad   = 0;

  assign I_IRQ = irq_lines;

  irq_ctrl #(
    .NUM_IRQ     (8),
    .SYNC_STAGES (2),
    .VEC_BASE    (16'h0002),
    .VEC_STRIDE  (2)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .I_IRQ    (I_IRQ),
    .I_CS     (I_CS),
    .I_WREN   (I_WREN),
    .I_REG    (I_REG),
    .I_DATA   (I_DATA),
    .O_DATA   (O_DATA),
    .O_IRQ    (O_IRQ),
    .O_VECTOR (O_VECTOR),
    .I_ACK    (I_ACK),
    .I_EOI    (I_EOI)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [1:0] idx, input logic [7:0] d);
    @(negedge CLOCK);
    I_CS = 1'b1; I_WREN = 1'b1; I_REG = idx; I_DATA = d;
    @(negedge CLOCK);
    I_CS = 1'b0; I_WREN = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] idx, output logic [7:0] d);
    @(negedge CLOCK);
    I_CS = 1'b1; I_WREN = 1'b0; I_REG = idx;
    @(negedge CLOCK);
    I_CS = 1'b0;
    d = O_DATA;
  endtask

  task automatic pulse_ack();
    @(negedge CLOCK);
    I_ACK = 1'b1;
    @(negedge CLOCK);
    I_ACK = 1'b0;
  endtask

  task automatic pulse_eoi();
    @(negedge CLOCK);
    I_EOI = 1'b1;
    @(negedge CLOCK);
    I_EOI = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (O_IRQ === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLOCK);
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", O_IRQ); end
    total++; if (O_VECTOR !== 16'h0000) begin bad++; $display("FAIL rst_vec got=%h exp=0000", O_VECTOR); end
    total++; if (O_DATA !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", O_DATA); end
    RESET_N = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(r[1:0], d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_reg%0d got=%h exp=00", r, d); end
    end
  endtask

  task automatic test_first_toggle();
    logic [7:0] d;
    reg_write(REG_MASK, 8'h01);
    @(negedge CLOCK);
    irq_lines[0] = 1'b1;
    repeat (4) @(negedge CLOCK);
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL tog_early got=%b exp=0", O_IRQ); end
    @(negedge CLOCK);
    total++; if (O_IRQ !== 1'b1) begin bad++; $display("FAIL tog_irq got=%b exp=1", O_IRQ); end
    total++; if (O_VECTOR !== 16'h0002) begin bad++; $display("FAIL tog_vec got=%h exp=0002", O_VECTOR); end
    pulse_ack();
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL tog_ack_drop got=%b exp=0", O_IRQ); end
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL tog_insv got=%h exp=01", d); end
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL tog_pend got=%h exp=00", d); end
    pulse_eoi();
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL tog_eoi got=%h exp=00", d); end
  endtask

  task automatic test_two_pending();
    logic [7:0] d;
    logic       hit;
    logic       seen;
    reg_write(REG_MASK, 8'h24);
    @(negedge CLOCK);
    irq_lines = irq_lines ^ 8'h24;
    wait_irq(20, hit);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL two_irq got=%b exp=1", hit); end
    total++; if (O_VECTOR !== 16'h0006) begin bad++; $display("FAIL two_vec2 got=%h exp=0006", O_VECTOR); end
    pulse_ack();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      seen = seen | O_IRQ;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL two_blocked got=%b exp=0", seen); end
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h20) begin bad++; $display("FAIL two_pend got=%h exp=20", d); end
    pulse_eoi();
    wait_irq(20, hit);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL two_irq5 got=%b exp=1", hit); end
    total++; if (O_VECTOR !== 16'h000C) begin bad++; $display("FAIL two_vec5 got=%h exp=000c", O_VECTOR); end
    pulse_ack();
    pulse_eoi();
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL two_insv got=%h exp=00", d); end
  endtask

  task automatic test_nested();
    logic [7:0] d;
    logic       hit;
    reg_write(REG_MASK, 8'h0A);
    @(negedge CLOCK);
    irq_lines[3] = ~irq_lines[3];
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h0008 || hit !== 1'b1) begin bad++; $display("FAIL nest_vec3 got=%h exp=0008", O_VECTOR); end
    pulse_ack();
    @(negedge CLOCK);
    irq_lines[1] = ~irq_lines[1];
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h0004 || hit !== 1'b1) begin bad++; $display("FAIL nest_vec1 got=%h exp=0004", O_VECTOR); end
    pulse_ack();
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL nest_insv got=%h exp=0a", d); end
    pulse_eoi();
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL nest_eoi1 got=%h exp=08", d); end
    pulse_eoi();
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL nest_eoi2 got=%h exp=00", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       hit;
    @(negedge CLOCK);
    irq_lines[3] = ~irq_lines[3];
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h0008 || hit !== 1'b1) begin bad++; $display("FAIL b2b_vec3 got=%h exp=0008", O_VECTOR); end
    irq_lines[1] = ~irq_lines[1];
    repeat (6) @(negedge CLOCK);
    total++; if (O_VECTOR !== 16'h0008 || O_IRQ !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%h exp=0008", O_VECTOR); end
    @(negedge CLOCK);
    I_ACK = 1'b1;
    @(negedge CLOCK);
    I_ACK = 1'b0;
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL b2b_m got=%b exp=0", O_IRQ); end
    @(negedge CLOCK);
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL b2b_m1 got=%b exp=0", O_IRQ); end
    @(negedge CLOCK);
    total++; if (O_IRQ !== 1'b1 || O_VECTOR !== 16'h0004) begin bad++; $display("FAIL b2b_m2 got=%b/%h exp=1/0004", O_IRQ, O_VECTOR); end
    @(negedge CLOCK);
    I_ACK = 1'b1; I_EOI = 1'b1;
    @(negedge CLOCK);
    I_ACK = 1'b0; I_EOI = 1'b0;
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL b2b_ack_eoi got=%h exp=02", d); end
    pulse_eoi();
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL b2b_insv got=%h exp=00", d); end
  endtask

  task automatic test_level();
    logic [7:0] d;
    logic       hit;
    logic       seen;
    reg_write(REG_MODE, 8'h10);
    reg_write(REG_MASK, 8'h10);
    @(negedge CLOCK);
    irq_lines[4] = 1'b1;
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h000A || hit !== 1'b1) begin bad++; $display("FAIL lvl_vec got=%h exp=000a", O_VECTOR); end
    pulse_ack();
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL lvl_pend_ack got=%h exp=10", d); end
    reg_write(REG_PEND, 8'h10);
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL lvl_w1c got=%h exp=10", d); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      seen = seen | O_IRQ;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL lvl_blocked got=%b exp=0", seen); end
    pulse_eoi();
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h000A || hit !== 1'b1) begin bad++; $display("FAIL lvl_rereq got=%h exp=000a", O_VECTOR); end
    irq_lines[4] = 1'b0;
    hit = 1'b1;
    for (int i = 0; i < 10 && hit; i++) begin
      @(negedge CLOCK);
      hit = O_IRQ;
    end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL lvl_withdraw got=%b exp=0", hit); end
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL lvl_insv got=%h exp=00", d); end
    reg_write(REG_MODE, 8'h00);
  endtask

  task automatic test_mask_withdraw();
    logic [7:0] d;
    logic       hit;
    reg_write(REG_MASK, 8'h40);
    @(negedge CLOCK);
    irq_lines[6] = ~irq_lines[6];
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h000E || hit !== 1'b1) begin bad++; $display("FAIL mwd_vec got=%h exp=000e", O_VECTOR); end
    reg_write(REG_MASK, 8'h00);
    total++; if (O_IRQ !== 1'b1) begin bad++; $display("FAIL mwd_hold got=%b exp=1", O_IRQ); end
    @(negedge CLOCK);
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL mwd_drop got=%b exp=0", O_IRQ); end
    reg_read(REG_INSV, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL mwd_insv got=%h exp=00", d); end
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h40) begin bad++; $display("FAIL mwd_pend got=%h exp=40", d); end
    reg_write(REG_PEND, 8'h40);
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL mwd_w1c got=%h exp=00", d); end
  endtask

  task automatic test_set_beats_w1c();
    logic [7:0] d;
    @(negedge CLOCK);
    irq_lines[2] = ~irq_lines[2];
    repeat (6) @(negedge CLOCK);
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL sw_pend got=%h exp=04", d); end
    // Second toggle lands in PENDING three edges after its first sampling edge,
    // the same edge the W1C is sampled.
    irq_lines[2] = ~irq_lines[2];
    repeat (3) @(negedge CLOCK);
    I_CS = 1'b1; I_WREN = 1'b1; I_REG = REG_PEND; I_DATA = 8'h04;
    @(negedge CLOCK);
    I_CS = 1'b0; I_WREN = 1'b0;
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL sw_set_wins got=%h exp=04", d); end
    reg_write(REG_PEND, 8'h04);
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL sw_clear got=%h exp=00", d); end
  endtask

  task automatic test_reset_hold();
    logic [7:0] d;
    logic       seen;
    @(negedge CLOCK);
    RESET_N   = 1'b0;
    irq_lines = 8'hFF;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    reg_write(REG_MASK, 8'hFF);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLOCK);
      seen = seen | O_IRQ;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL hold_irq got=%b exp=0", seen); end
    reg_read(REG_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL hold_pend got=%h exp=00", d); end
  endtask

  task automatic test_reset_mid_req();
    logic [7:0] d;
    logic       hit;
    @(negedge CLOCK);
    irq_lines[7] = 1'b0;
    wait_irq(20, hit);
    total++; if (O_VECTOR !== 16'h0010 || hit !== 1'b1) begin bad++; $display("FAIL mid_vec got=%h exp=0010", O_VECTOR); end
    #2;
    RESET_N = 1'b0;
    #1;
    total++; if (O_IRQ !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", O_IRQ); end
    total++; if (O_VECTOR !== 16'h0000) begin bad++; $display("FAIL mid_vec0 got=%h exp=0000", O_VECTOR); end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(r[1:0], d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_reg%0d got=%h exp=00", r, d); end
    end
  endtask

  initial begin
    test_reset();
    test_first_toggle();
    test_two_pending();
    test_nested();
    test_back_to_back();
    test_level();
    test_mask_withdraw();
    test_set_beats_w1c();
    test_reset_hold();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller between the peripheral event lines (keyboard, mouse, timer and future sources) and the 8-bit CPU core. Generalises the CPU's fixed three-source toggle detection to NUM_IRQ channels with per-channel mask, edge/level mode, pending and in-service tracking, fixed priority with nesting, and a vector/acknowledge handshake. Software configures it through a small byte-wide register port on the CPU data bus.

## Interface
- NUM_IRQ, 8 — channel count, 1..8; channel 0 is highest priority
- SYNC_STAGES, 2 — synchroniser depth on IRQ inputs, ≥1
- VEC_BASE, 16'h0002 — vector address of channel 0
- VEC_STRIDE, 2 — vector spacing in bytes
- CLOCK  in  1  system clock; all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- I_IRQ  in  NUM_IRQ  event lines; a change is a request in toggle mode, high is a request in level mode
- I_CS  in  1  register port select
- I_WREN  in  1  register write strobe, valid with I_CS
- I_REG  in  2  register index
- I_DATA  in  8  register write data
- O_DATA  out  8  register read data
- O_IRQ  out  1  interrupt request to CPU
- O_VECTOR  out  16  handler address, valid while O_IRQ=1
- I_ACK  in  1  one-cycle pulse: CPU has taken the vector
- I_EOI  in  1  one-cycle pulse: handler finished (RETI)

## Operation
- Register map (bits ≥NUM_IRQ read 0 and ignore writes): 0 MASK, 1=enabled; 1 MODE, 0=toggle, 1=level; 2 PENDING, read, write-1-to-clear; 3 INSERVICE, read-only.
- Toggle detect: synchronised input vs history flop; a difference sets PENDING[i]. History is primed from the synchronised input on the first cycle after reset; no request is generated then.
- Level mode: PENDING[i] follows the synchronised level; W1C has no effect.
- Candidate = PENDING & MASK & ~INSERVICE, limited to channels of higher priority than the highest in-service channel. Lowest index wins.
- FSM IDLE: a candidate exists → latch index k and O_VECTOR = VEC_BASE + k*VEC_STRIDE → REQ.
- FSM REQ: O_IRQ=1 and the vector is held stable. I_ACK → set INSERVICE[k], clear PENDING[k] in toggle mode, and go to IDLE. If PENDING[k] or MASK[k] drops before ACK, withdraw: O_IRQ=0 and go to IDLE. A higher-priority arrival during REQ does not change the latched vector.
- I_EOI clears the highest-priority set INSERVICE bit. EOI with INSERVICE=0 is ignored.
- Same-cycle conflicts: new toggle event and W1C on the same bit → the set wins. ACK and EOI in the same cycle → both are applied; EOI acts on INSERVICE before the ACK bit is set.
- Reset: MASK, MODE, PENDING, INSERVICE, history and synchronisers = 0; FSM=IDLE; O_IRQ=0; O_VECTOR=16'h0000; O_DATA=8'h00. Reset mid-REQ drops O_IRQ asynchronously.

## Timing
- Input toggle at edge n → PENDING set at edge n+SYNC_STAGES+1 → O_IRQ high one edge later.
- I_ACK sampled at edge m → O_IRQ low after m. Next request can assert at m+2 at the earliest.
- Register read: O_DATA valid the edge after I_CS & ~I_WREN; otherwise it holds its last value.
- Register write takes effect at the edge it is sampled. A MASK write drops a pending REQ at the following edge.
- The vector and O_IRQ are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package irq_pkg: FSM state enum (IDLE, REQ), register index constants (REG_MASK, REG_MODE, REG_PEND, REG_INSV), and the vector computation function.
- Sub-module irq_prio_enc: parametrised lowest-index-first priority encoder with valid output. It is instantiated twice: once for candidate selection and once for EOI in-service selection.

## Test plan
- Reset, then MASK=8'h01. Toggle I_IRQ[0] 0→1 → O_IRQ=1 and O_VECTOR=16'h0002 four edges later. ACK → INSERVICE=8'h01, PENDING=0.
- Channels 2 and 5 pending and enabled → vector 16'h0006. ACK. Channel 5 is not raised before EOI. EOI → vector 16'h000C.
- Channel 3 in service and channel 1 toggles → nested request with vector 16'h0004. Two EOIs clear bit 1, then bit 3.
- Level mode on channel 4 held high across ACK and EOI → re-requests after EOI. W1C on PENDING[4] has no effect.
- In REQ for channel 6, write MASK bit 6 to 0 → O_IRQ drops the next edge and no INSERVICE bit is set.
- Input held high through reset release → no request. Assert RESET_N low during REQ → O_IRQ=0 immediately and all registers read 0.
